mips_cpu_bus_master: RTL

// Bus initiator between the MIPS core datapath and the Avalon-style memory bus (address/read/write/

---
 rtl/mips_cpu_bus_pkg.sv | 32 +++
 rtl/mips_cpu_bus_master_if.sv | 25 ++
 rtl/mips_cpu_bus_lane_align.sv | 45 ++++
 rtl/mips_cpu_bus_master.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the MIPS core bus master.
// Holds access sizes, FSM states and the latched request record.
package mips_cpu_bus_pkg;

  localparam int unsigned BUS_WORD_BYTES = 4;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 8 * BUS_WORD_BYTES;
  localparam int unsigned BE_W           = BUS_WORD_BYTES;
  localparam int unsigned WAIT_W         = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Request attributes kept for the whole transaction.
  typedef struct packed {
    logic       is_data;
    logic       write;
    size_t      size;
    logic       sign;
    logic [1:0] lane;
  } req_t;

endpackage

// File: rtl/mips_cpu_bus_master_if.sv
// Avalon-style memory bus between the bus master and the RAM responder.
// master: drives address/read/write/byteenable/writedata, samples waitrequest/readdata.
// slave : the responder side.
interface mips_cpu_bus_master_if;
  import mips_cpu_bus_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );

endinterface

// File: rtl/mips_cpu_bus_lane_align.sv
// Combinational byte-lane steering for one bus access.
// Inputs : i_size, i_signed, i_lane (addr[1:0]), i_wdata (right-justified), i_readdata.
// Outputs: o_byteenable_c, o_writedata_c (lane-steered), o_rdata_c (extracted and
//          extended load data), o_misaligned_c.
module mips_cpu_bus_lane_align
  import mips_cpu_bus_pkg::*;
(
  input  size_t             i_size,
  input  logic              i_signed,
  input  logic [1:0]        i_lane,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_readdata,
  output logic [BE_W-1:0]   o_byteenable_c,
  output logic [DATA_W-1:0] o_writedata_c,
  output logic [DATA_W-1:0] o_rdata_c,
  output logic              o_misaligned_c
);

  logic [DATA_W-1:0] w_shifted;

  assign w_shifted     = i_readdata >> {i_lane, 3'b000};
  assign o_writedata_c = i_wdata << {i_lane, 3'b000};

  // Lane mask, load extraction and alignment check per access size.
  always_comb begin
    o_byteenable_c = 4'b1111;
    o_rdata_c      = w_shifted;
    o_misaligned_c = 1'b0;
    case (i_size)
      SIZE_BYTE: begin
        o_byteenable_c = 4'b0001 << i_lane;
        o_rdata_c      = {{(DATA_W-8){i_signed & w_shifted[7]}}, w_shifted[7:0]};
      end
      SIZE_HALF: begin
        o_byteenable_c = 4'b0011 << i_lane;
        o_rdata_c      = {{(DATA_W-16){i_signed & w_shifted[15]}}, w_shifted[15:0]};
        o_misaligned_c = i_lane[0];
      end
      default: begin
        o_misaligned_c = (i_lane != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_master.sv
// Bus initiator for the MIPS core: arbitrates fetch and load/store requests,
// runs one Avalon-style transaction at a time and returns extended read data.
// Ports: clk, reset (async, active-low);
//        fetch side  i_req/i_addr -> i_done/i_rdata;
//        data side   d_req/d_write/d_size/d_signed/d_addr/d_wdata -> d_done/d_rdata;
//        err pulses with done on misalignment or wait timeout;
//        bus (master modport) to the memory responder.
module mips_cpu_bus_master
  import mips_cpu_bus_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_done,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [1:0]            d_size,
  input  logic                  d_signed,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_done,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  err,
  mips_cpu_bus_master_if.master bus
);

  state_t              r_state;
  req_t                r_req;
  logic                r_read;
  logic                r_write;
  logic [ADDR_W-1:0]   r_address;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_i_done;
  logic                r_d_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  req_t                w_sel;
  logic [DATA_W-1:0]   w_wdata_in;
  logic [BE_W-1:0]     w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_misaligned;
  logic                w_timeout;

  // In IDLE the aligner sees the winning live request; afterwards the latched one.
  always_comb begin
    w_sel      = r_req;
    w_wdata_in = '0;
    if (r_state == IDLE) begin
      if (d_req) begin
        w_sel.is_data = 1'b1;
        w_sel.write   = d_write;
        w_sel.size    = size_t'(d_size);
        w_sel.sign    = d_signed;
        w_sel.lane    = d_addr[1:0];
        w_wdata_in    = d_wdata;
      end else begin
        w_sel.is_data = 1'b0;
        w_sel.write   = 1'b0;
        w_sel.size    = SIZE_WORD;
        w_sel.sign    = 1'b0;
        w_sel.lane    = i_addr[1:0];
      end
    end
  end

  mips_cpu_bus_lane_align u_align (
    .i_size         (w_sel.size),
    .i_signed       (w_sel.sign),
    .i_lane         (w_sel.lane),
    .i_wdata        (w_wdata_in),
    .i_readdata     (bus.readdata),
    .o_byteenable_c (w_be),
    .o_writedata_c  (w_wdata),
    .o_rdata_c      (w_rdata),
    .o_misaligned_c (w_misaligned)
  );

  // Last allowed stalled cycle; never true when the limit is disabled.
  assign w_timeout = (WAIT_LIMIT != 0) && (r_wait_cnt == WAIT_W'(WAIT_LIMIT - 1));

  // Transaction FSM with arbiter, wait counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_address  <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
      r_err      <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (d_req || i_req) begin
            r_req <= w_sel;
            if (w_misaligned) begin
              // Reject without touching the bus.
              r_state <= RESP;
              r_err   <= 1'b1;
              if (w_sel.is_data) begin
                r_d_done  <= 1'b1;
                r_d_rdata <= '0;
              end else begin
                r_i_done  <= 1'b1;
                r_i_rdata <= '0;
              end
            end else begin
              r_state    <= ACCESS;
              r_read     <= ~w_sel.write;
              r_write    <= w_sel.write;
              r_address  <= {(d_req ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2]), 2'b00};
              r_be       <= w_be;
              r_wdata    <= w_wdata;
              r_wait_cnt <= '0;
            end
          end
        end
        ACCESS: begin
          if (!bus.waitrequest) begin
            r_state <= RESP;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_req.is_data) begin
              r_d_done <= 1'b1;
              if (!r_req.write) r_d_rdata <= w_rdata;
            end else begin
              r_i_done  <= 1'b1;
              r_i_rdata <= w_rdata;
            end
          end else if (w_timeout) begin
            r_state <= RESP;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b1;
            if (r_req.is_data) begin
              r_d_done  <= 1'b1;
              r_d_rdata <= '0;
            end else begin
              r_i_done  <= 1'b1;
              r_i_rdata <= '0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.address    = r_address;
  assign bus.read       = r_read;
  assign bus.write      = r_write;
  assign bus.byteenable = r_be;
  assign bus.writedata  = r_wdata;

  assign i_done  = r_i_done;
  assign i_rdata = r_i_rdata;
  assign d_done  = r_d_done;
  assign d_rdata = r_d_rdata;
  assign err     = r_err;

endmodule
